// File: rtl/bus_gen_pkg.sv
// Shared definitions for the bus generator / round-robin arbiter.
//   bus_state_t : per-bus transfer phase (IDLE -> POP -> PUSH -> IDLE)
//   ID_W        : width of the destination-ID field at the top of a packet
//   PKT_MAX_W   : widest packet id_of() can decode
//   id_of()     : extracts the destination ID from a packet of width pkt_w
package bus_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bus_state_t;

    localparam int ID_W      = 8;
    localparam int PKT_MAX_W = 256;

    // The ID sits in the top ID_W bits of the packet. Packets are passed
    // zero-extended to PKT_MAX_W so one function serves every packet width.
    function automatic logic [ID_W-1:0] id_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int                   pkt_w);
        logic [PKT_MAX_W-1:0] shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/bus_rr_channel.sv
// One independent bus: round-robin grant among drvrs devices, pop of the
// granted device's head packet, then delivery (unicast / broadcast / drop).
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   pndng      : per-device FIFO non-empty flags
//   D_pop      : per-device head-of-FIFO packets
//   pop        : one-cycle consume pulse to the granted device
//   push       : one-cycle write pulses to the receiving device(s)
//   D_push     : delivered packet, identical on every device lane
module bus_rr_channel
    import bus_gen_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

    localparam int PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1;

    bus_state_t         state;
    logic [PTR_W-1:0]   ptr;          // last granted device
    logic [pckg_sz-1:0] pkt;          // packet being / last delivered

    logic               found;
    int                 cand;
    logic [PTR_W-1:0]   cand_idx;
    logic [PTR_W-1:0]   grant_idx;
    logic [drvrs-1:0]   grant_onehot;
    logic [ID_W-1:0]    dest;
    logic [drvrs-1:0]   push_dec;

    // First pending device strictly after ptr, ascending with wrap; ptr
    // itself is examined last so a lone requester is still served.
    always_comb begin
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        grant_idx = ptr;
        for (int k = 1; k <= drvrs; k++) begin
            cand = int'(ptr) + k;
            if (cand >= drvrs)
                cand = cand - drvrs;
            cand_idx = PTR_W'(cand);
            if (!found && pndng[cand_idx]) begin
                found     = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_onehot = '0;
        for (int i = 0; i < drvrs; i++)
            grant_onehot[i] = (i == int'(grant_idx));
    end

    // Decoded while in POP straight from the granted device's head so push
    // can be registered on the same edge the packet is captured.
    always_comb begin
        dest     = id_of(PKT_MAX_W'(D_pop[ptr]), pckg_sz);
        push_dec = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (dest == broadcast)
                push_dec[i] = (i != int'(ptr));
            else
                push_dec[i] = (int'(dest) == i);  // out-of-range IDs match nothing
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= PTR_W'(drvrs - 1);
            pkt   <= '0;
            pop   <= '0;
            push  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    push <= '0;
                    if (found) begin
                        ptr   <= grant_idx;
                        pop   <= grant_onehot;
                        state <= POP;
                    end
                end
                POP: begin
                    pop   <= '0;
                    pkt   <= D_pop[ptr];
                    push  <= push_dec;
                    state <= PUSH;
                end
                PUSH: begin
                    push  <= '0;
                    state <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < drvrs; gi++) begin : g_dpush
        assign D_push[gi] = pkt;
    end

endmodule

// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator and round-robin arbiter: bits independent buses, each
// with drvrs devices. Every bus is served by its own bus_rr_channel; this
// level only slices the per-bus arrays.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   pndng      : [bits][drvrs] device FIFO non-empty
//   D_pop      : [bits][drvrs][pckg_sz] head packets
//   pop        : [bits][drvrs] consume pulses
//   push       : [bits][drvrs] delivery pulses
//   D_push     : [bits][drvrs][pckg_sz] delivered packet per bus
module bus_generator_n_arbiter
    import bus_gen_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [bits-1:0][drvrs-1:0]               pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
    output logic [bits-1:0][drvrs-1:0]               pop,
    output logic [bits-1:0][drvrs-1:0]               push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

    for (genvar gi = 0; gi < bits; gi++) begin : g_bus
        bus_rr_channel #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_channel (
            .clk    (clk),
            .reset  (reset),
            .pndng  (pndng[gi]),
            .D_pop  (D_pop[gi]),
            .pop    (pop[gi]),
            .push   (push[gi]),
            .D_push (D_push[gi])
        );
    end

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
module tb_bus_generator_n_arbiter;

    localparam int ND = 5;
    localparam int PW = 16;
    localparam int FD = 32;

    logic                       clk   = 1'b0;
    logic                       reset = 1'b1;
    logic [0:0][ND-1:0]         pndng;
    logic [0:0][ND-1:0][PW-1:0] D_pop;
    logic [0:0][ND-1:0]         pop;
    logic [0:0][ND-1:0]         push;
    logic [0:0][ND-1:0][PW-1:0] D_push;

    bus_generator_n_arbiter #(
        .bits(1), .drvrs(ND), .pckg_sz(PW), .broadcast(8'h0F)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // device FIFOs
    logic [PW-1:0] fmem [ND][FD];
    int fhead [ND];
    int fcnt  [ND];

    // reference model state
    int            busy;        // cycles of the current transfer still to observe
    int            last_g;      // last granted device
    logic [PW-1:0] cur_pkt;
    logic [PW-1:0] dhold;       // value D_push must hold
    logic [ND-1:0] prev_pndng;  // pndng presented at the edge just passed
    int            cyc;
    int            grants[$];
    int            pop_cycles[$];
    logic [ND-1:0] last_push_obs;
    logic [PW-1:0] last_dpush_obs;

    function automatic logic [ND-1:0] exp_deliver(logic [PW-1:0] p, int src);
        int id;
        id = int'(p[15:8]);
        if (id == 15)     return 5'b11111 & ~(5'b00001 << src);
        else if (id < ND) return 5'b00001 << id;
        else              return 5'b00000;
    endfunction

    function automatic int next_grant(int last, logic [ND-1:0] req);
        for (int k = 1; k <= ND; k++)
            if (req[(last + k) % ND]) return (last + k) % ND;
        return -1;
    endfunction

    task automatic enqueue(int d, logic [PW-1:0] p);
        if (fcnt[d] < FD) begin
            fmem[d][(fhead[d] + fcnt[d]) % FD] = p;
            fcnt[d]++;
        end
    endtask

    task automatic drive_inputs();
        for (int d = 0; d < ND; d++) begin
            pndng[0][d] = (fcnt[d] > 0);
            D_pop[0][d] = (fcnt[d] > 0) ? fmem[d][fhead[d]] : PW'($urandom);
        end
        prev_pndng = pndng[0];
    endtask

    task automatic model_reset();
        busy   = 0;
        last_g = ND - 1;
        dhold  = '0;
    endtask

    // One clock of observation + model, at the falling edge.
    task automatic cycle();
        logic [ND-1:0] exp_pop;
        logic [ND-1:0] exp_push;
        bit consume;
        @(negedge clk);
        cyc++;
        exp_pop  = '0;
        exp_push = '0;
        consume  = 0;
        if (busy == 0) begin
            if (prev_pndng != 0) begin
                last_g  = next_grant(last_g, prev_pndng);
                exp_pop = 5'b00001 << last_g;
                cur_pkt = fmem[last_g][fhead[last_g]];
                busy    = 2;
                grants.push_back(last_g);
                pop_cycles.push_back(cyc);
            end
        end else if (busy == 2) begin
            exp_push       = exp_deliver(cur_pkt, last_g);
            dhold          = cur_pkt;
            busy           = 1;
            consume        = 1;
            last_push_obs  = push[0];
            last_dpush_obs = D_push[0][0];
        end else begin
            busy = 0;
        end
        checks++;
        if (pop[0] !== exp_pop) begin
            errors++;
            $display("FAIL pop cyc=%0d got=%b expected=%b", cyc, pop[0], exp_pop);
        end
        checks++;
        if (push[0] !== exp_push) begin
            errors++;
            $display("FAIL push cyc=%0d got=%b expected=%b", cyc, push[0], exp_push);
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (D_push[0][d] !== dhold) begin
                errors++;
                $display("FAIL d_push cyc=%0d lane=%0d got=%h expected=%h", cyc, d, D_push[0][d], dhold);
            end
        end
        if (consume) begin
            $display("xfer src=%0d pkt=%h push=%b expected=%b", last_g, cur_pkt, push[0], exp_push);
            fhead[last_g] = (fhead[last_g] + 1) % FD;
            fcnt[last_g]--;
        end
        drive_inputs();
    endtask

    function automatic bit all_idle();
        for (int d = 0; d < ND; d++) if (fcnt[d] != 0) return 0;
        return busy == 0;
    endfunction

    task automatic run_until_idle(int max_cycles);
        int n;
        n = 0;
        while (!all_idle() && n < max_cycles) begin
            cycle();
            n++;
        end
        checks++;
        if (!all_idle()) begin
            errors++;
            $display("FAIL drain_timeout got=%0d cycles expected<%0d", n, max_cycles);
        end
        cycle();  // one idle cycle: everything quiet
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        drive_inputs();
    endtask

    task automatic check_zero_outputs(string tag);
        checks++;
        if (pop[0] !== '0 || push[0] !== '0 || D_push[0] !== '0) begin
            errors++;
            $display("FAIL %s got pop=%b push=%b d_push0=%h expected all zero",
                     tag, pop[0], push[0], D_push[0][0]);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            pndng[0] = ND'($urandom);
            for (int d = 0; d < ND; d++) D_pop[0][d] = PW'($urandom);
            @(negedge clk);
            check_zero_outputs("reset_hold");
        end
        enqueue(0, 16'h0201);
        enqueue(3, 16'h0411);
        reset = 1'b0;
        model_reset();
        grants.delete();
        drive_inputs();
        run_until_idle(40);
        checks++;
        if (grants.size() != 2 || grants[0] != 0) begin
            errors++;
            $display("FAIL first_grant got=%0d expected=0", grants.size() > 0 ? grants[0] : -1);
        end
    endtask

    task automatic test_unicast();
        grants.delete();
        enqueue(1, 16'h03AB);
        drive_inputs();
        run_until_idle(20);
        checks++;
        if (grants.size() != 1 || grants[0] != 1 || last_push_obs !== 5'b01000 ||
            last_dpush_obs !== 16'h03AB) begin
            errors++;
            $display("FAIL unicast got push=%b d_push=%h expected push=01000 d_push=03ab",
                     last_push_obs, last_dpush_obs);
        end
    endtask

    task automatic test_broadcast();
        grants.delete();
        enqueue(2, 16'h0F55);
        drive_inputs();
        run_until_idle(20);
        checks++;
        if (last_push_obs !== 5'b11011 || last_dpush_obs !== 16'h0F55) begin
            errors++;
            $display("FAIL broadcast got push=%b d_push=%h expected push=11011 d_push=0f55",
                     last_push_obs, last_dpush_obs);
        end
    endtask

    task automatic test_round_robin();
        int exp_order[6];
        exp_order = '{0, 2, 4, 0, 2, 4};
        do_reset();
        grants.delete();
        pop_cycles.delete();
        for (int r = 0; r < 2; r++) begin
            enqueue(0, 16'h0100 | 16'(r));
            enqueue(2, 16'h0300 | 16'(r));
            enqueue(4, 16'h0000 | 16'(r));
        end
        drive_inputs();
        run_until_idle(60);
        checks++;
        if (grants.size() != 6) begin
            errors++;
            $display("FAIL rr_count got=%0d expected=6", grants.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grants[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, grants[i], exp_order[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (pop_cycles[i] - pop_cycles[i-1] != 3) begin
                        errors++;
                        $display("FAIL rr_spacing idx=%0d got=%0d expected=3",
                                 i, pop_cycles[i] - pop_cycles[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_invalid_and_self();
        grants.delete();
        enqueue(3, 16'h0712);
        enqueue(1, 16'h0099);
        enqueue(4, 16'h04CC);  // delivered back to its source
        drive_inputs();
        run_until_idle(40);
        checks++;
        if (grants.size() != 3) begin
            errors++;
            $display("FAIL invalid_served got=%0d expected=3", grants.size());
        end
    endtask

    task automatic test_random();
        logic [7:0] ids[8];
        ids = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0F, 8'h05, 8'h07};
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0)
                enqueue($urandom_range(0, ND - 1),
                        {ids[$urandom_range(0, 7)], 8'($urandom)});
            cycle();
        end
        run_until_idle(600);
    endtask

    task automatic test_mid_reset();
        int n;
        int exp_order[3];
        exp_order = '{0, 2, 4};
        do_reset();
        enqueue(2, 16'h0300);
        drive_inputs();
        n = 0;
        while (busy != 2 && n < 10) begin
            cycle();
            n++;
        end
        checks++;
        if (busy != 2) begin
            errors++;
            $display("FAIL midreset_pop got=none expected=pop on device 2");
        end
        reset = 1'b1;  // inside the POP cycle
        #1;
        check_zero_outputs("midreset_async");
        @(negedge clk);
        check_zero_outputs("midreset_hold");
        enqueue(0, 16'h0100);
        enqueue(4, 16'h0200);
        reset = 1'b0;
        model_reset();
        grants.delete();
        drive_inputs();
        run_until_idle(40);
        checks++;
        if (grants.size() != 3) begin
            errors++;
            $display("FAIL midreset_count got=%0d expected=3", grants.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grants[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL midreset_order idx=%0d got=%0d expected=%0d",
                             i, grants[i], exp_order[i]);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            fhead[d] = 0;
            fcnt[d]  = 0;
        end
        cyc = 0;
        last_push_obs  = '0;
        last_dpush_obs = '0;
        model_reset();
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_round_robin();
        test_invalid_and_self();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
